// File: rtl/pwm_msg_pkg.sv
// Shared types and defaults for the PWM message decoder.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package pwm_msg_pkg;

    typedef enum logic [1:0] {
        CFG_LEN,
        CFG_KEY,
        CFG_MASK,
        CFG_DONE
    } cfg_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_HIGH,
        RX_LOW
    } rx_state_e;

    localparam int DEF_MIN_SYM = 10;
    localparam int DEF_MAX_SYM = 60;

    // Width needed to hold a length value in 0..max_len.
    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/pwm_sym_detect.sv
// PWM symbol detector: measures high/low phases of str and judges each symbol.
// Latency: strobes are combinational in the cycle the terminating rising edge is sampled.
// Backpressure: none; the line cannot be stalled, every symbol is judged as it ends.
//
// Ports: clk, reset (async active-low), en (receive enabled; low holds RX_IDLE),
//        str (line), sym_done (a symbol ended this cycle), sym_bit (decoded bit,
//        valid with sym_done), sym_bad (the ended symbol was out of length range).
module pwm_sym_detect
    import pwm_msg_pkg::*;
#(
    parameter int CNT_W   = 6,
    parameter int MIN_SYM = DEF_MIN_SYM,
    parameter int MAX_SYM = DEF_MAX_SYM
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic str,
    output logic sym_done,
    output logic sym_bit,
    output logic sym_bad
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   MIN_T   = (CNT_W+1)'(MIN_SYM);
    localparam logic [CNT_W:0]   MAX_T   = (CNT_W+1)'(MAX_SYM);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic [CNT_W-1:0] zeros_q, zeros_d;
    logic             prev_q, prev_d;
    logic             rise;
    logic [CNT_W:0]   total;

    always_comb begin
        prev_d   = str;
        rise     = str & ~prev_q;
        total    = {1'b0, ones_q} + {1'b0, zeros_q};
        state_d  = state_q;
        ones_d   = ones_q;
        zeros_d  = zeros_q;
        sym_done = 1'b0;
        sym_bit  = 1'b0;
        sym_bad  = 1'b0;
        if (!en) begin
            state_d = RX_IDLE;
            ones_d  = '0;
            zeros_d = '0;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (str) begin
                        state_d = RX_HIGH;
                        ones_d  = CNT_ONE;
                        zeros_d = '0;
                    end
                end
                RX_HIGH: begin
                    if (str) begin
                        if (ones_q != CNT_MAX) ones_d = ones_q + CNT_ONE;
                    end else begin
                        state_d = RX_LOW;
                        zeros_d = CNT_ONE;
                    end
                end
                RX_LOW: begin
                    if (rise) begin
                        // The edge that ends this symbol is the first high cycle of the next.
                        sym_done = 1'b1;
                        sym_bad  = (total < MIN_T) || (total > MAX_T);
                        sym_bit  = (ones_q >= zeros_q);
                        state_d  = RX_HIGH;
                        ones_d   = CNT_ONE;
                        zeros_d  = '0;
                    end else if (zeros_q != CNT_MAX) begin
                        zeros_d = zeros_q + CNT_ONE;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            ones_q  <= '0;
            zeros_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            zeros_q <= zeros_d;
            prev_q  <= prev_d;
        end
    end

endmodule

// File: rtl/pwm_msg_decoder.sv
// PWM message receiver: serial config load, symbol-to-bit collection, descramble, re-serialise.
// Latency: msg_data/msg_valid/frame/first msg bit one cycle after the completing rising edge.
// Backpressure: none; consumer must accept msg_valid and the msg/frame stream as produced.
//
// Ports: clk, reset (async active-low), mode (1 = config load, 0 = receive), str (line),
//        msg_data (descrambled word, right-aligned), msg_valid (1-cycle pulse),
//        msg/frame (MSB-first serial copy of the word), cfg_ok (config complete and legal),
//        sym_err (1-cycle pulse per rejected symbol).
module pwm_msg_decoder
    import pwm_msg_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = calc_len_w(MAX_LEN),
    parameter int CNT_W   = 6,
    parameter int MIN_SYM = DEF_MIN_SYM,
    parameter int MAX_SYM = DEF_MAX_SYM
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic               str,
    output logic [MAX_LEN-1:0] msg_data,
    output logic               msg_valid,
    output logic               msg,
    output logic               frame,
    output logic               cfg_ok,
    output logic               sym_err
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    cfg_state_e         cfg_state_q, cfg_state_d, cfg_cur;
    logic [LEN_W-1:0]   cfg_cnt_q, cfg_cnt_d, cnt_cur;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] key_q, key_d, mask_q, mask_d;
    logic               mode_q, mode_d, mode_rise;
    logic               cfg_ok_q, cfg_ok_d;

    logic [MAX_LEN-1:0] raw_q, raw_d, raw_shift;
    logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [MAX_LEN-1:0] msg_data_q, msg_data_d;
    logic               msg_valid_q, msg_valid_d;
    logic               sym_err_q, sym_err_d;
    logic [MAX_LEN-1:0] tx_sh_q, tx_sh_d;
    logic [LEN_W-1:0]   tx_left_q, tx_left_d;
    logic               msg_q, msg_d, frame_q, frame_d;

    logic               rx_en, sym_done, sym_bit, sym_bad, bit_ok, word_done;
    logic [MAX_LEN-1:0] len_mask, word, word_aligned;
    logic [LEN_W-1:0]   tx_shamt;

    assign rx_en = ~mode & cfg_ok_q;

    pwm_sym_detect #(
        .CNT_W   (CNT_W),
        .MIN_SYM (MIN_SYM),
        .MAX_SYM (MAX_SYM)
    ) u_sym_detect (
        .clk      (clk),
        .reset    (reset),
        .en       (rx_en),
        .str      (str),
        .sym_done (sym_done),
        .sym_bit  (sym_bit),
        .sym_bad  (sym_bad)
    );

    // Configuration loader. A rising edge of mode restarts at CFG_LEN and the
    // bit present in that same cycle is already the first length bit.
    always_comb begin
        mode_d      = mode;
        mode_rise   = mode & ~mode_q;
        cfg_cur     = mode_rise ? CFG_LEN : cfg_state_q;
        cnt_cur     = mode_rise ? '0 : cfg_cnt_q;
        cfg_state_d = cfg_state_q;
        cfg_cnt_d   = cfg_cnt_q;
        len_d       = len_q;
        key_d       = key_q;
        mask_d      = mask_q;
        cfg_ok_d    = mode_rise ? 1'b0 : cfg_ok_q;
        if (mode) begin
            cfg_state_d = cfg_cur;
            cfg_cnt_d   = cnt_cur + LEN_ONE;
            case (cfg_cur)
                CFG_LEN: begin
                    len_d = {len_q[LEN_W-2:0], str};
                    if (cnt_cur == LEN_W'(LEN_W - 1)) begin
                        cfg_state_d = CFG_KEY;
                        cfg_cnt_d   = '0;
                    end
                end
                CFG_KEY: begin
                    key_d = {key_q[MAX_LEN-2:0], str};
                    if (cnt_cur == LEN_W'(MAX_LEN - 1)) begin
                        cfg_state_d = CFG_MASK;
                        cfg_cnt_d   = '0;
                    end
                end
                CFG_MASK: begin
                    mask_d = {mask_q[MAX_LEN-2:0], str};
                    if (cnt_cur == LEN_W'(MAX_LEN - 1)) begin
                        cfg_state_d = CFG_DONE;
                        cfg_cnt_d   = '0;
                        cfg_ok_d    = (len_q != '0) && (len_q <= LEN_W'(MAX_LEN));
                    end
                end
                default: cfg_cnt_d = cnt_cur;
            endcase
        end
    end

    // Bit collector, descrambler and serialiser.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
        bit_ok       = sym_done & ~sym_bad;
        raw_shift    = {raw_q[MAX_LEN-2:0], sym_bit};
        word         = ((raw_shift ^ key_q) | mask_q) & len_mask;
        word_done    = bit_ok && ((bit_cnt_q + LEN_ONE) == len_q);
        // Left-justify the word so the serialiser always emits from the top bit.
        tx_shamt     = LEN_W'(MAX_LEN) - len_q;
        word_aligned = word << tx_shamt;

        raw_d       = raw_q;
        bit_cnt_d   = bit_cnt_q;
        msg_data_d  = msg_data_q;
        msg_valid_d = 1'b0;
        sym_err_d   = sym_done & sym_bad;
        tx_sh_d     = tx_sh_q;
        tx_left_d   = tx_left_q;
        msg_d       = msg_q;
        frame_d     = frame_q;

        if (mode) begin
            raw_d     = '0;
            bit_cnt_d = '0;
        end else if (word_done) begin
            raw_d       = '0;
            bit_cnt_d   = '0;
            msg_data_d  = word;
            msg_valid_d = 1'b1;
        end else if (bit_ok) begin
            raw_d     = raw_shift;
            bit_cnt_d = bit_cnt_q + LEN_ONE;
        end

        // Serialiser keeps running across mode changes; a new word cannot
        // arrive before the previous one is fully shifted out.
        if (word_done) begin
            msg_d     = word_aligned[MAX_LEN-1];
            frame_d   = 1'b1;
            tx_sh_d   = word_aligned << 1;
            tx_left_d = len_q - LEN_ONE;
        end else if (tx_left_q != '0) begin
            msg_d     = tx_sh_q[MAX_LEN-1];
            tx_sh_d   = tx_sh_q << 1;
            tx_left_d = tx_left_q - LEN_ONE;
        end else begin
            msg_d   = 1'b0;
            frame_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_state_q <= CFG_LEN;
            cfg_cnt_q   <= '0;
            len_q       <= '0;
            key_q       <= '0;
            mask_q      <= '0;
            mode_q      <= 1'b0;
            cfg_ok_q    <= 1'b0;
            raw_q       <= '0;
            bit_cnt_q   <= '0;
            msg_data_q  <= '0;
            msg_valid_q <= 1'b0;
            sym_err_q   <= 1'b0;
            tx_sh_q     <= '0;
            tx_left_q   <= '0;
            msg_q       <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            cfg_state_q <= cfg_state_d;
            cfg_cnt_q   <= cfg_cnt_d;
            len_q       <= len_d;
            key_q       <= key_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            cfg_ok_q    <= cfg_ok_d;
            raw_q       <= raw_d;
            bit_cnt_q   <= bit_cnt_d;
            msg_data_q  <= msg_data_d;
            msg_valid_q <= msg_valid_d;
            sym_err_q   <= sym_err_d;
            tx_sh_q     <= tx_sh_d;
            tx_left_q   <= tx_left_d;
            msg_q       <= msg_d;
            frame_q     <= frame_d;
        end
    end

    assign msg_data  = msg_data_q;
    assign msg_valid = msg_valid_q;
    assign msg       = msg_q;
    assign frame     = frame_q;
    assign cfg_ok    = cfg_ok_q;
    assign sym_err   = sym_err_q;

endmodule
